// File: rtl/crop_norm_pkg.sv
// rtl/crop_norm_pkg.sv - shared state type and helpers for the crop normalizer
package crop_norm_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    CALC  = 2'd2,
    DRAIN = 2'd3
  } state_e;

  // Address counters never shrink below one bit, even for a 1-pixel frame
  localparam int MIN_ADDR_W = 1;

  function automatic int addr_width(input int npix);
    return (npix > 1) ? $clog2(npix) : MIN_ADDR_W;
  endfunction

  // Leading-zero count of a pixel over 'width' bits; a zero pixel yields 0
  // so an empty frame passes through unshifted.
  function automatic int lzc(input logic [31:0] pix, input int width);
    int n;
    n = 0;
    for (int i = 0; i < 32; i++) begin
      if ((i < width) && pix[i]) begin
        n = width - 1 - i;
      end
    end
    return n;
  endfunction

endpackage

// File: rtl/crop_norm_frame_ram.sv
// rtl/crop_norm_frame_ram.sv - simple dual-port frame store with registered read
module crop_norm_frame_ram #(
  parameter int DEPTH = 100,
  parameter int WIDTH = 10,
  parameter int AW    = 7
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             re_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  // Write port; the array carries no reset so it maps onto block RAM
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem[waddr_i] <= wdata_i;
    end
  end

  // Registered read port, one cycle of latency
  always_ff @(posedge clk) begin
    if (re_i) begin
      rdata_q <= mem[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/crop_normalizer.sv
// rtl/crop_normalizer.sv - buffers a cropped frame and replays it power-of-two normalized (option: FRAME_STATS_EN)
module crop_normalizer
  import crop_norm_pkg::*;
#(
  parameter int PIXEL_BIT_WIDTH = 10,
  parameter int OUT_ROWS        = 10,
  parameter int OUT_COLS        = 10
) (
  input  logic                       clk,
  input  logic                       srst,
  input  logic                       ap_start,
  output logic                       ap_done,
  input  logic                       s_axis_tvalid,
  output logic                       s_axis_tready,
  input  logic [PIXEL_BIT_WIDTH-1:0] s_axis_tdata,
  output logic                       m_axis_tvalid,
  input  logic                       m_axis_tready,
  output logic [PIXEL_BIT_WIDTH-1:0] m_axis_tdata,
  output logic                       m_axis_tlast
`ifdef FRAME_STATS_EN
  ,
  output logic [PIXEL_BIT_WIDTH-1:0] frame_max,
  output logic [((PIXEL_BIT_WIDTH > 1) ? $clog2(PIXEL_BIT_WIDTH) : 1)-1:0] norm_shift
`endif
);

  localparam int W    = PIXEL_BIT_WIDTH;
  localparam int NPIX = OUT_ROWS * OUT_COLS;
  localparam int AW   = addr_width(NPIX);
  localparam int SW   = (W > 1) ? $clog2(W) : 1;
  localparam logic [AW-1:0] LAST_ADDR = AW'(NPIX - 1);

  state_e state_q, state_d;

  logic [AW-1:0] wr_addr_q;
  logic [AW-1:0] rd_addr_q;
  logic [AW-1:0] out_cnt_q;
  logic          rd_done_q;
  logic          rd_pend_q;
  logic [W-1:0]  max_q;
  logic [SW-1:0] shift_q;
  logic          ap_done_q;

  // Two-entry output skid: e0 is the presented beat, e1 the one behind it
  logic [W-1:0]  e0_q, e1_q;
  logic [1:0]    cnt_q;

  logic          fill_hs;
  logic          pop;
  logic          out_last;
  logic          rd_issue;
  logic [2:0]    occ_next;
  logic [W-1:0]  ram_rdata;
  logic [W-1:0]  din;

  assign fill_hs  = (state_q == FILL) && s_axis_tvalid;
  assign pop      = m_axis_tvalid && m_axis_tready;
  assign out_last = (out_cnt_q == LAST_ADDR);
  assign din      = ram_rdata << shift_q;

  // A read is issued only if its data is sure to find a free skid slot,
  // counting the read already in flight and the beat leaving this cycle.
  assign occ_next = {1'b0, cnt_q} + {2'b0, rd_pend_q} - {2'b0, pop};
  assign rd_issue = (state_q == DRAIN) && !rd_done_q && (occ_next < 3'd2);

  assign s_axis_tready = (state_q == FILL);
  assign m_axis_tvalid = (cnt_q != 2'd0);
  assign m_axis_tlast  = m_axis_tvalid && out_last;
  assign m_axis_tdata  = e0_q;
  assign ap_done       = ap_done_q;

  crop_norm_frame_ram #(
    .DEPTH (NPIX),
    .WIDTH (W),
    .AW    (AW)
  ) u_ram (
    .clk     (clk),
    .we_i    (fill_hs),
    .waddr_i (wr_addr_q),
    .wdata_i (s_axis_tdata),
    .re_i    (rd_issue),
    .raddr_i (rd_addr_q),
    .rdata_o (ram_rdata)
  );

  // State register
  always_ff @(posedge clk or posedge srst) begin
    if (srst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: fill a frame, one cycle to size the shift, then drain it
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (ap_start) state_d = FILL;
      FILL:    if (fill_hs && (wr_addr_q == LAST_ADDR)) state_d = CALC;
      CALC:    state_d = DRAIN;
      DRAIN:   if (pop && out_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Write side: address counter and running frame maximum
  always_ff @(posedge clk or posedge srst) begin
    if (srst) begin
      wr_addr_q <= '0;
      max_q     <= '0;
    end else if ((state_q == IDLE) && ap_start) begin
      wr_addr_q <= '0;
      max_q     <= '0;
    end else if (fill_hs) begin
      wr_addr_q <= (wr_addr_q == LAST_ADDR) ? '0 : wr_addr_q + 1'b1;
      if (s_axis_tdata > max_q) begin
        max_q <= s_axis_tdata;
      end
    end
  end

  // Shift sizing in CALC and read-side address bookkeeping during DRAIN
  always_ff @(posedge clk or posedge srst) begin
    if (srst) begin
      shift_q   <= '0;
      rd_addr_q <= '0;
      rd_done_q <= 1'b0;
      rd_pend_q <= 1'b0;
      out_cnt_q <= '0;
      ap_done_q <= 1'b0;
    end else begin
      ap_done_q <= pop && out_last;
      rd_pend_q <= rd_issue;
      if (state_q == CALC) begin
        shift_q   <= SW'(lzc(32'(max_q), W));
        rd_addr_q <= '0;
        rd_done_q <= 1'b0;
        out_cnt_q <= '0;
      end else begin
        if (rd_issue) begin
          rd_addr_q <= (rd_addr_q == LAST_ADDR) ? '0 : rd_addr_q + 1'b1;
          if (rd_addr_q == LAST_ADDR) begin
            rd_done_q <= 1'b1;
          end
        end
        if (pop) begin
          out_cnt_q <= out_last ? '0 : out_cnt_q + 1'b1;
        end
      end
    end
  end

  // Skid buffer: RAM data arrives one cycle after issue, beats leave in order
  always_ff @(posedge clk or posedge srst) begin
    if (srst) begin
      e0_q  <= '0;
      e1_q  <= '0;
      cnt_q <= 2'd0;
    end else begin
      case ({pop, rd_pend_q})
        2'b11: begin
          if (cnt_q == 2'd1) begin
            e0_q <= din;
          end else begin
            e0_q <= e1_q;
            e1_q <= din;
          end
        end
        2'b10: begin
          e0_q  <= e1_q;
          cnt_q <= cnt_q - 2'd1;
        end
        2'b01: begin
          if (cnt_q == 2'd0) begin
            e0_q <= din;
          end else begin
            e1_q <= din;
          end
          cnt_q <= cnt_q + 2'd1;
        end
        default: begin
        end
      endcase
    end
  end

`ifdef FRAME_STATS_EN
  logic [W-1:0] stat_max_q;

  // Frame statistics snapshot, refreshed once per frame in CALC
  always_ff @(posedge clk or posedge srst) begin
    if (srst) begin
      stat_max_q <= '0;
    end else if (state_q == CALC) begin
      stat_max_q <= max_q;
    end
  end

  assign frame_max  = stat_max_q;
  assign norm_shift = shift_q;
`endif

endmodule
